prog_timer: RTL and testbench

Parametrised programmable interval timer.
- A prescaler divides clk into a periodic enable "tick".
- A WIDTH-bit counter steps once per tick, up or down, in periodic (auto-reload) or one-shot mode.
- Generates a terminal-count "done" pulse.
- Replaces fixed free-running second counters in board-level designs: seconds display, LED blink, timeouts.

---
 rtl/prog_timer.sv | 100 ++++++++++
 tb/tb_prog_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// prog_timer: prescaled up/down interval timer, periodic or one-shot.
// Ports: clk, rst (async low); en, clr, load, load_val, dir, one_shot, limit in; count, tick, done, running out.
module prog_timer #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned WIDTH    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             running
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             stop_q, stop_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic active;
  logic wrap;
  logic term;

  assign active = en & ~stop_q;
  assign wrap   = (psc_q == PMAX);
  // ">=" so a limit lowered under count ends on the next step
  assign term   = dir ? (count_q == '0)
                      : (count_q >= limit);

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    stop_d  = stop_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      psc_d   = '0;
      stop_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      psc_d   = '0;
      stop_d  = 1'b0;
    end else if (active) begin
      if (wrap) begin
        psc_d  = '0;
        tick_d = 1'b1;
        if (term) begin
          done_d = 1'b1;
          if (one_shot) begin
            stop_d = 1'b1;
          end else begin
            count_d = dir ? limit : '0;
          end
        end else begin
          count_d = dir ? (count_q - ONE)
                        : (count_q + ONE);
        end
      end else begin
        psc_d = psc_q + PONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      psc_q   <= '0;
      stop_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      stop_q  <= stop_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign running = active;

endmodule

// File: tb/tb_prog_timer.sv
// Testbench for prog_timer: random and directed stimulus, queue scoreboard.
// Drives all ports; checks count/tick/done/running every cycle.
module tb_prog_timer;

  localparam int P = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, load, dir, one_shot;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         tick, done, running;

  typedef struct {
    int cnt;
    bit tick;
    bit done;
    bit run;
  } rec_t;

  rec_t exp_q[$];

  int tests = 0;
  int fails = 0;

  int m_cnt, m_ph;
  bit m_stop;

  prog_timer #(.PRESCALE(P), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .load(load), .load_val(load_val), .dir(dir),
    .one_shot(one_shot), .limit(limit),
    .count(count), .tick(tick), .done(done),
    .running(running)
  );

  always #5 clk = ~clk;

  // Reference: what the outputs must be after the next edge
  task automatic push();
    rec_t r;
    r.tick = 0;
    r.done = 0;
    if (clr) begin
      m_cnt = 0; m_ph = 0; m_stop = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_ph = 0; m_stop = 0;
    end else if (en && !m_stop) begin
      m_ph = m_ph + 1;
      if (m_ph == P) begin
        bit fin;
        m_ph = 0;
        r.tick = 1;
        fin = dir ? (m_cnt == 0) : (m_cnt >= int'(limit));
        if (fin) begin
          r.done = 1;
          if (one_shot) m_stop = 1;
          else m_cnt = dir ? int'(limit) : 0;
        end else begin
          m_cnt = dir ? m_cnt - 1 : m_cnt + 1;
        end
      end
    end
    r.cnt = m_cnt % (1 << W);
    r.run = en && !m_stop;
    exp_q.push_back(r);
  endtask

  task automatic run(int n);
    repeat (n) begin
      push();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic bound_fail(string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      tests++;
      if (int'(count) != e.cnt || tick !== e.tick ||
          done !== e.done || running !== e.run) begin
        fails++;
        $display("FAIL cycle t=%0t: cnt/tick/done/run got %0d/%b/%b/%b, expected %0d/%b/%b/%b",
                 $time, count, tick, done, running,
                 e.cnt, e.tick, e.done, e.run);
      end
    end
  end

  task automatic wait_for(string nm, int c, int ph);
    int k;
    k = 0;
    while (!(m_cnt == c && m_ph == ph) && k < 200) begin
      run(1);
      k++;
    end
    if (k >= 200) bound_fail(nm);
  endtask

  initial begin
    rst = 1'b0;
    en = 0; clr = 0; load = 0; dir = 0; one_shot = 0;
    load_val = '0; limit = '0;
    m_cnt = 0; m_ph = 0; m_stop = 0;
    #3;
    check("rst_count", int'(count), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_done", int'(done), 0);
    check("rst_running", int'(running), 0);

    // 1: up periodic, limit 3
    @(negedge clk);
    #1;
    rst = 1'b1;
    en = 1;
    limit = 4'd3;
    run(40);

    // 2: down one-shot from 2, then reload 5
    load = 1; load_val = 4'd2; dir = 1; one_shot = 1;
    run(1);
    load = 0;
    run(52);
    load = 1; load_val = 4'd5;
    run(1);
    load = 0;
    run(10);

    // 3: en gap two cycles after a tick
    one_shot = 0;
    limit = 4'd9;
    wait_for("align_gate", 3, 2);
    en = 0;
    run(7);
    en = 1;
    run(6);

    // 4: clr+load on a due wrap at count == limit
    dir = 0;
    limit = 4'd3;
    wait_for("align_coll", 3, 3);
    clr = 1; load = 1; load_val = 4'd9;
    run(1);
    clr = 0;
    run(1);
    load = 0;
    run(8);

    // 5: limit lowered below count
    limit = 4'd15;
    load = 1; load_val = 4'd7;
    run(1);
    load = 0;
    limit = 4'd2;
    run(8);

    // 6: async reset at count 5 mid-period
    limit = 4'd15;
    load = 1; load_val = 4'd3;
    run(1);
    load = 0;
    wait_for("align_rst", 5, 2);
    rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_done", int'(done), 0);
    m_cnt = 0; m_ph = 0; m_stop = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    run(10);

    // random phase
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 10) != 0;
      clr = ($urandom % 40) == 0;
      load = ($urandom % 25) == 0;
      load_val = W'($urandom);
      if ($urandom % 30 == 0) dir = ~dir;
      if ($urandom % 40 == 0) one_shot = ~one_shot;
      if ($urandom % 20 == 0) limit = W'($urandom);
      run(1);
    end
    clr = 0; load = 0;
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
